// File: rtl/inst_buffer_pkg.sv
// Shared frontend constants and the instruction-buffer entry / fetch-lane layouts.
package inst_buffer_pkg;
  localparam int IBUF_BLOCK_INST_SIZE = 8;
  localparam int IBUF_FETCH_WIDTH     = 4;
  localparam int IBUF_FSQ_WIDTH       = 4;
  localparam int IBUF_DEPTH           = 16;

  typedef logic [31:0]               inst_t;
  typedef logic [IBUF_FSQ_WIDTH-1:0] fsq_idx_t;

  typedef struct packed {
    inst_t    inst;
    fsq_idx_t fsq_idx;
  } ibuf_entry_t;

  // One lane of the fetch bundle handed to the backend.
  typedef struct packed {
    logic     en;
    inst_t    inst;
    fsq_idx_t fsq_idx;
  } fetch_lane_t;
endpackage

// File: rtl/inst_buffer_if.sv
// Predecode-in / backend-out bus of the instruction buffer.
interface inst_buffer_if
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH           = IBUF_DEPTH,
  parameter int BLOCK_INST_SIZE = IBUF_BLOCK_INST_SIZE,
  parameter int FETCH_WIDTH     = IBUF_FETCH_WIDTH
);
  localparam int NW = $clog2(BLOCK_INST_SIZE) + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [BLOCK_INST_SIZE-1:0]                     pd_en;
  logic [NW-1:0]                                  pd_num;
  logic [BLOCK_INST_SIZE-1:0][31:0]               pd_inst;
  logic [IBUF_FSQ_WIDTH-1:0]                      pd_fsqIdx;
  logic                                           full;
  logic                                           flush;
  logic                                           stall;
  logic [FETCH_WIDTH-1:0]                         out_en;
  logic [FETCH_WIDTH-1:0][31:0]                   out_inst;
  logic [FETCH_WIDTH-1:0][IBUF_FSQ_WIDTH-1:0]     out_fsqIdx;
  logic [CW-1:0]                                  count;

  modport master (
    output pd_en, pd_num, pd_inst, pd_fsqIdx, flush, stall,
    input  full, out_en, out_inst, out_fsqIdx, count
  );

  modport slave (
    input  pd_en, pd_num, pd_inst, pd_fsqIdx, flush, stall,
    output full, out_en, out_inst, out_fsqIdx, count
  );
endinterface

// File: rtl/inst_buffer_lane.sv
// One registered output lane of the fetch bundle.
module inst_buffer_lane
  import inst_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        load_i,
  input  fetch_lane_t lane_d_i,
  output fetch_lane_t lane_q_o
);
  fetch_lane_t lane_q;

  // Payload only moves with a valid entry, so idle lanes keep quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= '0;
    end else if (flush_i) begin
      lane_q.en <= 1'b0;
    end else if (load_i) begin
      lane_q.en <= lane_d_i.en;
      if (lane_d_i.en) begin
        lane_q.inst    <= lane_d_i.inst;
        lane_q.fsq_idx <= lane_d_i.fsq_idx;
      end
    end
  end

  assign lane_q_o = lane_q;
endmodule

// File: rtl/inst_buffer.sv
// Circular instruction buffer: up to BLOCK_INST_SIZE in, up to FETCH_WIDTH out per cycle.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH           = IBUF_DEPTH,
  parameter int BLOCK_INST_SIZE = IBUF_BLOCK_INST_SIZE,
  parameter int FETCH_WIDTH     = IBUF_FETCH_WIDTH
)(
  input logic          clk,
  input logic          rst,
  inst_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d, enq_num, deq_num, avail;
  logic          full, enq, deq;
  ibuf_entry_t   mem_q [DEPTH];

  // Full looks only at registered occupancy; a same-cycle dequeue earns no credit.
  assign full    = cnt_q > CW'(DEPTH - BLOCK_INST_SIZE);
  assign enq     = |bus.pd_en && !full && !bus.flush;
  assign deq     = !bus.stall && !bus.flush;
  assign avail   = (cnt_q < CW'(FETCH_WIDTH)) ? cnt_q : CW'(FETCH_WIDTH);
  assign enq_num = enq ? CW'(bus.pd_num) : '0;
  assign deq_num = deq ? avail : '0;
  assign head_d  = head_q + deq_num[PW-1:0];
  assign tail_d  = tail_q + enq_num[PW-1:0];
  assign cnt_d   = cnt_q + enq_num - deq_num;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (bus.flush) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
        if (bus.pd_en[i]) begin
          mem_q[tail_q + PW'(i)] <= '{inst: bus.pd_inst[i], fsq_idx: bus.pd_fsqIdx};
        end
      end
    end
  end

  for (genvar j = 0; j < FETCH_WIDTH; j++) begin : g_lane
    logic [PW-1:0] raddr;
    fetch_lane_t   lane_d, lane_q;

    assign raddr  = head_q + PW'(j);
    assign lane_d = '{en:      avail > CW'(j),
                      inst:    mem_q[raddr].inst,
                      fsq_idx: mem_q[raddr].fsq_idx};

    inst_buffer_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (bus.flush),
      .load_i   (deq),
      .lane_d_i (lane_d),
      .lane_q_o (lane_q)
    );

    assign bus.out_en[j]     = lane_q.en;
    assign bus.out_inst[j]   = lane_q.inst;
    assign bus.out_fsqIdx[j] = lane_q.fsq_idx;
  end

  assign bus.full  = full;
  assign bus.count = cnt_q;
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: flow, full, wrap, stall, flush, async reset.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  inst_buffer_if bif ();

  inst_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic blk(input logic [31:0] base, input int num, input logic [3:0] fsq);
    bif.pd_en   = '0;
    bif.pd_inst = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < num) begin
        bif.pd_en[i]   = 1'b1;
        bif.pd_inst[i] = base + 32'(i);
      end
    end
    bif.pd_num    = 4'(num);
    bif.pd_fsqIdx = fsq;
  endtask

  task automatic idle();
    bif.pd_en  = '0;
    bif.pd_num = '0;
  endtask

  function automatic logic [127:0] q4(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  initial begin
    rst = 1'b1;
    bif.flush = 1'b0;
    bif.stall = 1'b0;
    bif.pd_fsqIdx = '0;
    bif.pd_inst = '0;
    idle();
    #2 rst = 1'b0;
    #1;
    chk("rst_out_en",  bif.out_en,   0);
    chk("rst_out_inst", bif.out_inst, 0);
    chk("rst_count",   bif.count,    0);
    chk("rst_full",    bif.full,     0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // basic flow
    blk(32'h100, 8, 4'd3);
    tick();
    idle();
    chk("basic_n1_en",    bif.out_en, 0);
    chk("basic_n1_count", bif.count,  8);
    tick();
    chk("basic_n2_en",   bif.out_en,     4'hF);
    chk("basic_n2_inst", bif.out_inst,   q4(32'h100));
    chk("basic_n2_fsq",  bif.out_fsqIdx, 16'h3333);
    tick();
    chk("basic_n3_inst", bif.out_inst,   q4(32'h104));
    chk("basic_n3_fsq",  bif.out_fsqIdx, 16'h3333);
    tick();
    chk("basic_n4_en",   bif.out_en, 0);

    // full / back-pressure
    bif.stall = 1'b1;
    blk(32'h200, 8, 4'd1);
    tick();
    chk("full_c8_count", bif.count, 8);
    chk("full_c8_full",  bif.full,  0);
    blk(32'h210, 8, 4'd2);
    tick();
    chk("full_c16_count", bif.count, 16);
    chk("full_c16_full",  bif.full,  1);
    blk(32'h220, 8, 4'd5);
    tick();
    tick();
    chk("full_held_count", bif.count,  16);
    chk("full_held_en",    bif.out_en, 0);
    bif.stall = 1'b0;
    tick();
    chk("full_rel1_count", bif.count,    12);
    chk("full_rel1_inst",  bif.out_inst, q4(32'h200));
    tick();
    chk("full_rel2_count", bif.count,    8);
    chk("full_rel2_full",  bif.full,     0);
    tick();
    idle();
    chk("full_acc_count", bif.count,    12);
    chk("full_acc_inst",  bif.out_inst, q4(32'h210));
    tick();
    chk("full_b2_inst", bif.out_inst, q4(32'h214));
    tick();
    chk("full_c1_inst", bif.out_inst,   q4(32'h220));
    chk("full_c1_fsq",  bif.out_fsqIdx, 16'h5555);
    tick();
    chk("full_c2_inst",  bif.out_inst, q4(32'h224));
    chk("full_c2_count", bif.count,    0);
    tick();
    chk("full_drain_en", bif.out_en, 0);

    // wrap: two 7-instruction prefixes move head/tail to 14
    blk(32'h300, 7, 4'd0);
    tick();
    idle();
    tick();
    tick();
    chk("pre_tail_en",   bif.out_en,         4'b0111);
    chk("pre_tail_inst", bif.out_inst[2:0], {32'h306, 32'h305, 32'h304});
    blk(32'h310, 7, 4'd0);
    tick();
    idle();
    tick();
    tick();
    chk("pre2_count", bif.count, 0);
    blk(32'h400, 5, 4'd7);
    tick();
    idle();
    chk("wrap_count", bif.count, 5);
    tick();
    chk("wrap_out1_en",   bif.out_en,     4'hF);
    chk("wrap_out1_inst", bif.out_inst,   q4(32'h400));
    chk("wrap_out1_fsq",  bif.out_fsqIdx, 16'h7777);
    tick();
    chk("wrap_out2_en",   bif.out_en,      4'b0001);
    chk("wrap_out2_inst", bif.out_inst[0], 32'h404);
    tick();
    chk("wrap_drain_en", bif.out_en, 0);

    // stall hold with a concurrent enqueue
    blk(32'h500, 8, 4'hA);
    tick();
    idle();
    tick();
    chk("stall_pre_inst", bif.out_inst, q4(32'h500));
    bif.stall = 1'b1;
    blk(32'h510, 4, 4'hB);
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      chk("stall_hold_en",    bif.out_en,     4'hF);
      chk("stall_hold_inst",  bif.out_inst,   q4(32'h500));
      chk("stall_hold_fsq",   bif.out_fsqIdx, 16'hAAAA);
      chk("stall_hold_count", bif.count,      8);
    end
    bif.stall = 1'b0;
    tick();
    chk("stall_rel_inst",  bif.out_inst, q4(32'h504));
    chk("stall_rel_count", bif.count,    4);
    tick();
    chk("stall_enq_inst", bif.out_inst,   q4(32'h510));
    chk("stall_enq_fsq",  bif.out_fsqIdx, 16'hBBBB);
    tick();
    chk("stall_drain_en", bif.out_en, 0);

    // flush with count 10, stall and an incoming block
    bif.stall = 1'b1;
    blk(32'h600, 8, 4'd1);
    tick();
    blk(32'h610, 2, 4'd1);
    tick();
    chk("flush_pre_count", bif.count, 10);
    chk("flush_pre_full",  bif.full,  1);
    bif.flush = 1'b1;
    blk(32'h700, 8, 4'd2);
    tick();
    bif.flush = 1'b0;
    bif.stall = 1'b0;
    idle();
    chk("flush_count", bif.count,  0);
    chk("flush_en",    bif.out_en, 0);
    tick();
    tick();
    chk("flush_drop_en",    bif.out_en, 0);
    chk("flush_drop_count", bif.count,  0);
    blk(32'h800, 3, 4'd6);
    tick();
    idle();
    tick();
    chk("post_flush_en",   bif.out_en,         4'b0111);
    chk("post_flush_inst", bif.out_inst[2:0], {32'h802, 32'h801, 32'h800});
    chk("post_flush_fsq",  bif.out_fsqIdx[2:0], 12'h666);
    tick();

    // asynchronous reset between edges
    blk(32'h900, 8, 4'd3);
    tick();
    idle();
    tick();
    chk("mid_pre_en", bif.out_en, 4'hF);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_en",    bif.out_en,     0);
    chk("mid_rst_inst",  bif.out_inst,   0);
    chk("mid_rst_fsq",   bif.out_fsqIdx, 0);
    chk("mid_rst_count", bif.count,      0);
    chk("mid_rst_full",  bif.full,       0);
    #3 rst = 1'b1;
    tick();
    blk(32'hA00, 4, 4'd9);
    tick();
    idle();
    chk("after_rst_n1_en",    bif.out_en, 0);
    chk("after_rst_n1_count", bif.count,  4);
    tick();
    chk("after_rst_n2_en",   bif.out_en,     4'hF);
    chk("after_rst_n2_inst", bif.out_inst,   q4(32'hA00));
    chk("after_rst_n2_fsq",  bif.out_fsqIdx, 16'h9999);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
